// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master, WIDTH bits per transfer, SCLK half-period of
// CLK_DIV clk cycles. Optional macro SPI_MASTER_LSB_FIRST_EN selects LSB-first
// bit order; MSB-first is the default build.
//
// Handshake: a transfer is accepted on any clk edge where start=1 and
// ready=1; ready is high only in IDLE, so start is ignored while busy. rx_valid
// is a one-cycle pulse marking the cycle in which rx_data takes a new word.
module spi_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             CS_n,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    XFER_HI = 3'd2,
    XFER_LO = 3'd3,
    GAP     = 3'd4
  } state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             last_q, last_d;      // final SCLK high phase has completed
  logic [WIDTH-1:0] tx_q, tx_d;          // transmit shift register
  logic [WIDTH-1:0] rxs_q, rxs_d;        // receive shift register
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tick;
  logic             active;
  logic             tx_first;

  assign tick = (div_q == DIV_LAST);

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign tx_first = tx_q[0];
`else
  assign tx_first = tx_q[WIDTH-1];
`endif

  // Next-state logic: every non-IDLE state lasts CLK_DIV cycles; the divider
  // reloads on each state change. Shifting happens on the edge ending XFER_HI.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q + DIV_W'(1);
    bit_d      = bit_q;
    last_d     = last_q;
    tx_d       = tx_q;
    rxs_d      = rxs_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_d  = '0;
        bit_d  = '0;
        last_d = 1'b0;
        if (start) begin
          tx_d    = tx_data;
          rxs_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          div_d   = '0;
          state_d = XFER_HI;
        end
      end
      XFER_HI: begin
        if (tick) begin
          div_d   = '0;
          state_d = XFER_LO;
`ifdef SPI_MASTER_LSB_FIRST_EN
          rxs_d = {MISO, rxs_q[WIDTH-1:1]};
          tx_d  = {1'b0, tx_q[WIDTH-1:1]};
`else
          rxs_d = {rxs_q[WIDTH-2:0], MISO};
          tx_d  = {tx_q[WIDTH-2:0], 1'b0};
`endif
          // Counter stops at WIDTH-1; the flag marks the last bit instead of a wrap.
          if (bit_q == BIT_LAST) begin
            last_d = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      XFER_LO: begin
        if (tick) begin
          div_d = '0;
          if (last_q) begin
            state_d    = GAP;
            rx_data_d  = rxs_q;
            rx_valid_d = 1'b1;
          end else begin
            state_d = XFER_HI;
          end
        end
      end
      GAP: begin
        if (tick) begin
          div_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        div_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      last_q     <= 1'b0;
      tx_q       <= '0;
      rxs_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      last_q     <= last_d;
      tx_q       <= tx_d;
      rxs_q      <= rxs_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Bus outputs are decoded from registered state only.
  assign active      = (state_q == SETUP) || (state_q == XFER_HI) || (state_q == XFER_LO);
  assign ready       = (state_q == IDLE);
  assign CS_n        = ~active;
  assign SCLK        = (state_q == XFER_HI);
  assign MOSI        = active & tx_first;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed vector table for spi_master (WIDTH=8, CLK_DIV=2),
// with a mode-0 slave model and hand sequences for back-to-back transfers and
// mid-transfer reset. Expected values follow SPI_MASTER_LSB_FIRST_EN.
module tb_spi_master;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ready, rx_valid, cs_n, sclk, mosi, miso;
  logic [7:0] rx_data;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  spi_master #(.WIDTH(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
    .ready(ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .CS_n(cs_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso),
    .dbg_state_o(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- slave model (mode 0, MSB-first on MISO) ----------------
  logic       loop_mode = 1'b0;
  logic [7:0] s_word = 8'h00;
  logic [7:0] s_rx = 8'h00;
  int         s_rises = 0;

  always @(posedge sclk or negedge cs_n) begin
    if (!sclk) begin
      s_rises = 0;
      s_rx    = 8'h00;
    end else begin
      s_rx    = {s_rx[6:0], mosi};
      s_rises = s_rises + 1;
    end
  end

  always_comb begin
    int k;
    k = sclk ? s_rises - 1 : s_rises;
    if (loop_mode)          miso = mosi;
    else if (k >= 0 && k < 8) miso = s_word[7-k];
    else                    miso = 1'b0;
  end

  // ---------------- bus monitor ----------------
  logic mon_en = 1'b0;
  int   cs_low_cnt = 0, sclk_rises = 0, gap_run = 0, last_gap = 0;
  int   rxv_cnt = 0, mosi_glitch = 0, idle_viol = 0;
  logic mosi_hi_seen = 1'b0;
  logic cs_prev = 1'b1, sclk_prev = 1'b0, mosi_prev = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!cs_n && cs_prev) begin
        cs_low_cnt   = 1;
        sclk_rises   = 0;
        last_gap     = gap_run;
        mosi_hi_seen = 1'b0;
      end else if (!cs_n) begin
        cs_low_cnt = cs_low_cnt + 1;
      end
      if (cs_n) gap_run = gap_run + 1;
      else      gap_run = 0;
      if (sclk && !sclk_prev) sclk_rises = sclk_rises + 1;
      if (sclk && sclk_prev && (mosi != mosi_prev)) mosi_glitch = mosi_glitch + 1;
      if (cs_n && (mosi || sclk)) idle_viol = idle_viol + 1;
      if (!cs_n && mosi) mosi_hi_seen = 1'b1;
      if (rx_valid) rxv_cnt = rxv_cnt + 1;
      cs_prev   = cs_n;
      sclk_prev = sclk;
      mosi_prev = mosi;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        break;
      end
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic wait_rxv(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_valid) begin
        got = 1'b1;
        break;
      end
    end
    check(name, 32'(got), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [7:0] tx;
    logic       loop;
    logic [7:0] s_word;
    logic [7:0] exp_rx;      // master rx_data
    logic [7:0] exp_srx;     // word assembled MSB-first by the slave
    logic       exp_first;   // first MOSI bit
    logic       exp_mosi_hi; // MOSI high at any point while CS_n low
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  task automatic run_vec(input int idx, input vec_t v);
    int rxv0;
    loop_mode = v.loop;
    s_word    = v.s_word;
    wait_ready($sformatf("v%0d_ready_wait", idx));
    rxv0 = rxv_cnt;
    @(posedge clk); #1;
    start   = 1'b1;
    tx_data = v.tx;
    @(negedge clk);
    check($sformatf("v%0d_accept_ready", idx), 32'(ready), 32'd1);
    @(posedge clk); #1;
    start   = 1'b0;
    tx_data = ~v.tx;
    @(negedge clk);
    check($sformatf("v%0d_busy_ready", idx), 32'(ready), 32'd0);
    check($sformatf("v%0d_cs_low", idx), 32'(cs_n), 32'd0);
    check($sformatf("v%0d_setup_sclk", idx), 32'(sclk), 32'd0);
    check($sformatf("v%0d_first_bit", idx), 32'(mosi), 32'(v.exp_first));
    wait_rxv($sformatf("v%0d_rxv_timeout", idx));
    check($sformatf("v%0d_rx_data", idx), 32'(rx_data), 32'(v.exp_rx));
    check($sformatf("v%0d_cs_low_cycles", idx), 32'(cs_low_cnt), 32'd34);
    check($sformatf("v%0d_sclk_rises", idx), 32'(sclk_rises), 32'd8);
    check($sformatf("v%0d_slave_rx", idx), 32'(s_rx), 32'(v.exp_srx));
    check($sformatf("v%0d_mosi_hi", idx), 32'(mosi_hi_seen), 32'(v.exp_mosi_hi));
    @(negedge clk);
    check($sformatf("v%0d_rxv_single", idx), 32'(rx_valid), 32'd0);
    wait_ready($sformatf("v%0d_ready_return", idx));
    check($sformatf("v%0d_rxv_count", idx), 32'(rxv_cnt - rxv0), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rxv0;
    bit got;

`ifdef SPI_MASTER_LSB_FIRST_EN
    //             tx     loop  s_word exp_rx exp_srx first mosi_hi
    vecs[0] = '{8'hA5, 1'b1, 8'h00, 8'hA5, 8'hA5, 1'b1, 1'b1};
    vecs[1] = '{8'h00, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hC3, 1'b0, 8'h3C, 8'h3C, 8'hC3, 1'b1, 1'b1};
    vecs[4] = '{8'h01, 1'b0, 8'h80, 8'h01, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h35, 1'b0, 8'h0F, 8'hF0, 8'hAC, 1'b1, 1'b1};
`else
    vecs[0] = '{8'hA5, 1'b1, 8'h00, 8'hA5, 8'hA5, 1'b1, 1'b1};
    vecs[1] = '{8'h00, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hC3, 1'b0, 8'h3C, 8'h3C, 8'hC3, 1'b1, 1'b1};
    vecs[4] = '{8'h01, 1'b0, 8'h80, 8'h80, 8'h01, 1'b0, 1'b1};
    vecs[5] = '{8'h35, 1'b0, 8'h0F, 8'h0F, 8'h35, 1'b0, 1'b1};
`endif

    // Reset and its output values.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Back-to-back: start held high, tx_data changed mid-transfer.
    loop_mode = 1'b1;
    @(posedge clk); #1;
    start   = 1'b1;
    tx_data = 8'h5A;
    @(posedge clk); #1;
    tx_data = 8'h81;
    wait_rxv("b2b_rxv1_timeout");
    check("b2b_rx_first", 32'(rx_data), 32'h5A);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!cs_n) begin
        got = 1'b1;
        break;
      end
    end
    check("b2b_second_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b_cs_high_gap", 32'(last_gap), 32'd3);
    wait_rxv("b2b_rxv2_timeout");
    check("b2b_rx_second", 32'(rx_data), 32'h81);
    check("b2b_cs_low_cycles", 32'(cs_low_cnt), 32'd34);
    wait_ready("b2b_ready_return");

    // Mid-transfer reset after the 3rd SCLK rise, with start asserted alongside.
    loop_mode = 1'b0;
    s_word    = 8'hFF;
    @(posedge clk); #1;
    start   = 1'b1;
    tx_data = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (sclk_rises >= 3 && !cs_n) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_mid_third_rise", 32'(got), 32'd1);
    rxv0 = rxv_cnt;
    @(posedge clk); #1;
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("rst_mid_cs_n", 32'(cs_n), 32'd1);
    check("rst_mid_sclk", 32'(sclk), 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_rx_data", 32'(rx_data), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    repeat (40) @(negedge clk);
    check("rst_mid_no_rxv", 32'(rxv_cnt - rxv0), 32'd0);
    check("rst_mid_still_idle", 32'(cs_n), 32'd1);

    // Bus-wide properties accumulated by the monitor.
    check("mosi_stable_while_sclk_high", 32'(mosi_glitch), 32'd0);
    check("idle_gap_bus_quiet", 32'(idle_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog against any unbounded stall.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning bits per transfer (legal range >= 2).
REQ-002 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal range >= 1).
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1, transfer request, qualified by ready.
REQ-006 The block SHALL have port tx_data, input, WIDTH, word to transmit, sampled at acceptance.
REQ-007 The block SHALL have port ready, output, 1, high when idle and able to accept start.
REQ-008 The block SHALL have port rx_data, output, WIDTH, last word received, held until the next transfer completes.
REQ-009 The block SHALL have port rx_valid, output, 1, single-cycle pulse when rx_data updates.
REQ-010 The block SHALL have port CS_n, output, 1, active-low chip select.
REQ-011 The block SHALL have port SCLK, output, 1, serial clock.
REQ-012 The block SHALL have port MOSI, output, 1, serial data out.
REQ-013 The block SHALL have port MISO, input, 1, serial data in.

Function
REQ-014 The block SHALL implement SPI mode 0: SCLK idles low; MOSI is stable before each rising edge; MISO is sampled at each rising edge; MOSI changes only while SCLK is low.
REQ-015 The block SHALL accept a transfer on any cycle t with start=1 and ready=1: it latches tx_data, drives ready low from t+1, and drives CS_n low from t+1.
REQ-016 The block SHALL ignore start while ready=0; an in-flight transfer and tx_data latch SHALL be unaffected.
REQ-017 The block SHALL use states IDLE -> SETUP -> XFER_HI <-> XFER_LO -> GAP -> IDLE, with every state except IDLE lasting exactly CLK_DIV cycles.
REQ-018 In SETUP, the block SHALL hold SCLK=0, CS_n=0, and MOSI = first bit of the latched word.
REQ-019 In XFER_HI, the block SHALL hold SCLK=1; on the clk edge that ends XFER_HI, it SHALL shift MISO into the receive register and increment the bit counter.
REQ-020 In XFER_LO, the block SHALL hold SCLK=0 and present the next transmit bit on MOSI from the first XFER_LO cycle; after the WIDTH-th XFER_LO (hold phase), it SHALL go to GAP.
REQ-021 CS_n SHALL be low for exactly CLK_DIV*(2*WIDTH+1) cycles per transfer, and exactly WIDTH rising SCLK edges SHALL occur while CS_n is low.
REQ-022 In GAP, the block SHALL hold CS_n=1, SCLK=0, and MOSI=0.
REQ-023 On the first GAP cycle, rx_data SHALL update and rx_valid SHALL pulse for exactly one cycle.
REQ-024 ready SHALL return high on the cycle after GAP ends; a start on that same cycle SHALL be accepted, so the minimum CS_n high time between transfers is CLK_DIV+1 cycles.
REQ-025 In IDLE, the block SHALL hold SCLK=0, MOSI=0, CS_n=1, and rx_valid=0.
REQ-026 The bit counter SHALL count 0..WIDTH-1 and SHALL NOT wrap within a transfer; the divider counter SHALL reload at every state change.
REQ-027 MISO SHALL be treated as synchronous to clk; no synchronizer is required.

Reset
REQ-028 While rst_n=0 at a clk edge, the block SHALL enter IDLE with CS_n=1, SCLK=0, MOSI=0, ready=1, rx_valid=0, rx_data=0, and all counters=0.
REQ-029 If reset is asserted mid-transfer, the block SHALL abort the transfer with no rx_valid pulse and drive CS_n=1 on the cycle after the reset edge.
REQ-030 Reset SHALL take priority over start on the same cycle.

Configuration
REQ-031 The macro SPI_MASTER_LSB_FIRST_EN SHALL select bit order: when defined, the block SHALL transmit tx_data[0] first and shift received bits in at the MSB end (first received bit lands in rx_data[0]).
REQ-032 When SPI_MASTER_LSB_FIRST_EN is undefined (default), the block SHALL transmit tx_data[WIDTH-1] first and shift received bits in at the LSB end (first received bit lands in rx_data[WIDTH-1]).
REQ-033 All timing, states, and handshakes SHALL be identical in both configurations.

Verification
REQ-034 WIDTH=8, CLK_DIV=2, MISO looped to MOSI, start with tx_data=0xA5 -> 8 SCLK rising edges, CS_n low 34 cycles, rx_valid pulse once, rx_data=0xA5.
REQ-035 MISO tied 1, tx_data=0x00 -> MOSI=0 throughout, rx_data=0xFF; then MISO tied 0 -> rx_data=0x00.
REQ-036 start held high continuously with tx_data changed mid-transfer -> first word sent unchanged, second transfer accepted on the cycle ready returns high, CS_n high exactly 3 cycles between transfers (CLK_DIV=2).
REQ-037 rst_n pulsed low after the 3rd SCLK rising edge -> CS_n=1, SCLK=0, ready=1 next cycle, no rx_valid, rx_data=0x00.
REQ-038 An external mode-0 slave model returns 0x3C against tx_data=0xC3 -> slave receives 0xC3, master rx_data=0x3C.
REQ-039 With SPI_MASTER_LSB_FIRST_EN defined, tx_data=0x01 -> first MOSI bit=1 and remaining 7 bits=0; slave MSB-first pattern 0x80 on MISO -> rx_data=0x01.
